// File: rtl/arith_pkg.sv
// Shared constants for the registered arithmetic primitives.
package arith_pkg;

  // Width used when an adder is instantiated without an explicit WIDTH.
  localparam int ADDER_WIDTH_DEFAULT = 4;

  // Supported operand width range.
  localparam int ADDER_WIDTH_MIN = 1;
  localparam int ADDER_WIDTH_MAX = 64;

endpackage

// File: rtl/ripple_carry_adder_full_adder.sv
// Single-bit full adder; one cell of the ripple carry chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic w_p;

  // Propagate term is shared by the sum bit and the carry-out.
  assign w_p  = a ^ b;
  assign s    = w_p ^ cin;
  assign cout = (a & b) | (cin & w_p);

endmodule

// File: rtl/ripple_carry_adder.sv
// Registered ripple-carry adder: {Cout,Sum} = A + B + Cin, one-cycle latency,
// with signed overflow and a valid strobe travelling alongside the data.
module ripple_carry_adder
  import arith_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             out_valid
);

  // w_c[i] is the carry into bit i; w_c[WIDTH] is the carry out of the MSB.
  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_s;
  logic             w_ovf;

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_vld;

  assign w_c[0] = Cin;

  // Carry ripples strictly LSB to MSB through one cell per bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a    (A[i]),
      .b    (B[i]),
      .cin  (w_c[i]),
      .s    (w_s[i]),
      .cout (w_c[i+1])
    );
  end

  // Signed overflow: carry into MSB differs from carry out of MSB.
  // For WIDTH=1 the carry into the MSB is Cin itself.
  assign w_ovf = w_c[WIDTH] ^ w_c[WIDTH-1];

  // Result registers load only on valid input and hold otherwise;
  // reset wins over a simultaneous valid and discards any in-flight result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (in_valid) begin
      r_sum  <= w_s;
      r_cout <= w_c[WIDTH];
      r_ovf  <= w_ovf;
    end
  end

  // Valid strobe is a one-stage delayed copy of in_valid.
  always_ff @(posedge clk) begin
    if (rst) r_vld <= 1'b0;
    else     r_vld <= in_valid;
  end

  assign Sum       = r_sum;
  assign Cout      = r_cout;
  assign Ovf       = r_ovf;
  assign out_valid = r_vld;

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Self-checking bench: a 4-bit and a 16-bit adder driven in lockstep,
// expected results queued at drive time and popped when the output updates.
module tb_ripple_carry_adder;

  typedef struct packed {
    logic        ovf;
    logic        cout;
    logic [15:0] sum;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, cin;
  logic [15:0] a, b;

  logic [3:0]  sum4;
  logic        cout4, ovf4, vld4;
  logic [15:0] sum16;
  logic        cout16, ovf16, vld16;

  int n_assert = 0;
  int n_fail   = 0;

  exp_t q4[$];
  exp_t q16[$];
  exp_t last4, last16;

  always #5 clk = ~clk;

  ripple_carry_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a[3:0]), .B(b[3:0]), .Cin(cin),
    .Sum(sum4), .Cout(cout4), .Ovf(ovf4), .out_valid(vld4)
  );

  ripple_carry_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a), .B(b), .Cin(cin),
    .Sum(sum16), .Cout(cout16), .Ovf(ovf16), .out_valid(vld16)
  );

  // Reference: arithmetic in wide integers, overflow from signed range.
  function automatic exp_t model(int w, logic [15:0] x, logic [15:0] y, logic c);
    longint mask, ux, uy, t, sx, sy, st;
    exp_t e;
    mask = (longint'(1) << w) - 1;
    ux   = longint'(x) & mask;
    uy   = longint'(y) & mask;
    t    = ux + uy + longint'(c);
    sx   = (ux >= (longint'(1) << (w-1))) ? ux - (longint'(1) << w) : ux;
    sy   = (uy >= (longint'(1) << (w-1))) ? uy - (longint'(1) << w) : uy;
    st   = sx + sy + longint'(c);
    e.sum  = 16'(t & mask);
    e.cout = t[w];
    e.ovf  = (st > (longint'(1) << (w-1)) - 1) || (st < -(longint'(1) << (w-1)));
    return e;
  endfunction

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, push expectations, clock, then pop and compare.
  task automatic step(logic r, logic v, logic [15:0] x, logic [15:0] y, logic c, string tag);
    rst = r; in_valid = v; a = x; b = y; cin = c;
    if (!r && v) begin
      q4.push_back(model(4, x, y, c));
      q16.push_back(model(16, x, y, c));
    end
    @(posedge clk);
    #1;
    if (r) begin
      q4.delete(); q16.delete();
      last4 = '0; last16 = '0;
    end else if (v) begin
      n_assert++;
      assert (q4.size() > 0 && q16.size() > 0) else begin
        n_fail++;
        $error("FAIL %s scoreboard observed=empty expected=entry", tag);
      end
      if (q4.size() > 0)  last4  = q4.pop_front();
      if (q16.size() > 0) last16 = q16.pop_front();
    end
    chk({tag, ".vld4"},   16'(vld4),   16'(!r && v));
    chk({tag, ".sum4"},   16'(sum4),   last4.sum);
    chk({tag, ".cout4"},  16'(cout4),  16'(last4.cout));
    chk({tag, ".ovf4"},   16'(ovf4),   16'(last4.ovf));
    chk({tag, ".vld16"},  16'(vld16),  16'(!r && v));
    chk({tag, ".sum16"},  sum16,       last16.sum);
    chk({tag, ".cout16"}, 16'(cout16), 16'(last16.cout));
    chk({tag, ".ovf16"},  16'(ovf16),  16'(last16.ovf));
  endtask

  initial begin
    last4 = '0; last16 = '0;
    rst = 1'b1; in_valid = 1'b1; a = 16'hF; b = 16'hF; cin = 1'b0;

    // Reset held two cycles with valid operands present.
    step(1, 1, 16'h000F, 16'h000F, 0, "rst0");
    step(1, 1, 16'h000F, 16'h000F, 0, "rst1");

    // Directed cases (Ovf expectations come from the model, e.g. 3+5 -> 1).
    step(0, 1, 16'h0003, 16'h0005, 0, "nocarry");
    chk("nocarry.direct", {11'd0, ovf4, cout4, sum4}, {11'd0, 1'b1, 1'b0, 4'b1000});
    step(0, 1, 16'h000B, 16'h0007, 0, "carry");
    chk("carry.direct",   {11'd0, ovf4, cout4, sum4}, {11'd0, 1'b0, 1'b1, 4'b0010});
    step(0, 1, 16'h000F, 16'h0000, 1, "ripple");
    chk("ripple.direct",  {11'd0, ovf4, cout4, sum4}, {11'd0, 1'b0, 1'b1, 4'b0000});
    step(0, 0, 16'h0001, 16'h0001, 0, "hold");
    chk("hold.direct",    {10'd0, vld4, ovf4, cout4, sum4}, {10'd0, 1'b0, 1'b0, 1'b1, 4'b0000});

    // Back-to-back results on consecutive cycles.
    step(0, 1, 16'h0007, 16'h0001, 0, "b2b0");
    chk("b2b0.direct",    {11'd0, ovf4, cout4, sum4}, {11'd0, 1'b1, 1'b0, 4'b1000});
    step(0, 1, 16'h0008, 16'h0008, 0, "b2b1");
    chk("b2b1.direct",    {11'd0, ovf4, cout4, sum4}, {11'd0, 1'b1, 1'b1, 4'b0000});

    // Reset in the second input cycle beats the valid operands.
    step(0, 1, 16'h0007, 16'h0001, 0, "prio0");
    step(1, 1, 16'h0008, 16'h0008, 0, "prio1");
    step(0, 0, 16'h0003, 16'h0003, 0, "prio2");

    // Exhaustive 4-bit sweep (upper bits exercise the 16-bit instance too).
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        for (int k = 0; k < 2; k++)
          step(0, 1, 16'(i) | 16'(j << 8), 16'(j) | 16'(i << 12), k[0], "exh");

    // Random 16-bit operands with occasional idle cycles.
    for (int n = 0; n < 300; n++)
      step(0, ($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
           1'($urandom_range(0, 1)), "rnd");

    // 16-bit boundaries: full ripple and signed extremes.
    step(0, 1, 16'hFFFF, 16'h0000, 1, "w16ripple");
    step(0, 1, 16'h7FFF, 16'h0000, 1, "w16posovf");
    step(0, 1, 16'h8000, 16'h8000, 0, "w16negovf");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
